// File: rtl/video_pkg.sv
// Shared video definitions: scheduler state encoding, VRAM owner IDs and
// default phase budgets used by the line-render sequencer.
package video_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_BG,
    ST_SPR,
    ST_DONE
  } sched_state_t;

  localparam logic [1:0] OWNER_EVAL = 2'd0;
  localparam logic [1:0] OWNER_BG   = 2'd1;
  localparam logic [1:0] OWNER_SPR  = 2'd2;

  localparam int EVAL_MAX_DEF = 80;
  localparam int BG_MAX_DEF   = 140;
  localparam int SPR_MAX_DEF  = 40;

  localparam int ADDR_W = 13;
  localparam int LINE_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that parks at zero; tc is high whenever the count is
// zero, which the scheduler reads as "this phase has used its budget".
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Stopping at zero instead of wrapping keeps tc asserted until the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/render_sched.sv
// Per-line render sequencer: walks EVAL -> BG -> SPR -> DONE, grants the
// video-side VRAM port to the active phase and tags returning read data.
module render_sched
  import video_pkg::*;
#(
  parameter int EVAL_MAX = EVAL_MAX_DEF,
  parameter int BG_MAX   = BG_MAX_DEF,
  parameter int SPR_MAX  = SPR_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LINE_W-1:0] line,
  input  logic [ADDR_W-1:0] eval_addr,
  input  logic [ADDR_W-1:0] bg_addr,
  input  logic [ADDR_W-1:0] spr_addr,
  input  logic              eval_done,
  input  logic              bg_done,
  input  logic              spr_done,
  output logic [ADDR_W-1:0] vaddr,
  output logic              rd_valid,
  output logic [1:0]        rd_owner,
  output logic              eval_start,
  output logic              bg_start,
  output logic              spr_start,
  output logic [LINE_W-1:0] line_out,
  output logic              busy,
  output logic              line_done,
  output logic              overrun,
  output logic              timeout
);

  localparam int CNT_MAX = max3(EVAL_MAX, BG_MAX, SPR_MAX);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sched_state_t state, next_state;

  logic              timer_tc;
  logic              timer_load;
  logic [CNT_W-1:0]  timer_val;
  logic              eval_start_nxt, bg_start_nxt, spr_start_nxt, overrun_nxt;
  logic              latch_line;
  logic              phase_done;
  logic              grant_valid;
  logic [1:0]        grant_owner;
  logic [ADDR_W-1:0] grant_addr;
  logic              p1_valid;
  logic [1:0]        p1_owner;

  phase_timer #(.WIDTH(CNT_W)) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (timer_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The timer is loaded with MAX-1 on phase entry, so tc lands on the MAX-th
  // cycle of the phase; start wins over done/timeout, and done masks timeout.
  always_comb begin
    next_state     = state;
    eval_start_nxt = 1'b0;
    bg_start_nxt   = 1'b0;
    spr_start_nxt  = 1'b0;
    overrun_nxt    = 1'b0;
    latch_line     = 1'b0;
    timer_load     = 1'b0;
    timer_val      = '0;
    timeout        = 1'b0;
    phase_done     = 1'b0;
    grant_valid    = 1'b0;
    grant_owner    = OWNER_EVAL;
    grant_addr     = eval_addr;

    case (state)
      ST_EVAL: begin
        grant_valid = 1'b1;
        grant_owner = OWNER_EVAL;
        grant_addr  = eval_addr;
        phase_done  = eval_done;
      end
      ST_BG: begin
        grant_valid = 1'b1;
        grant_owner = OWNER_BG;
        grant_addr  = bg_addr;
        phase_done  = bg_done;
      end
      ST_SPR: begin
        grant_valid = 1'b1;
        grant_owner = OWNER_SPR;
        grant_addr  = spr_addr;
        phase_done  = spr_done;
      end
      default: ;
    endcase

    if (start) begin
      next_state     = ST_EVAL;
      eval_start_nxt = 1'b1;
      latch_line     = 1'b1;
      overrun_nxt    = grant_valid;
      timer_load     = 1'b1;
      timer_val      = CNT_W'(EVAL_MAX - 1);
    end else if (grant_valid && (phase_done || timer_tc)) begin
      timeout = !phase_done;
      case (state)
        ST_EVAL: begin
          next_state   = ST_BG;
          bg_start_nxt = 1'b1;
          timer_load   = 1'b1;
          timer_val    = CNT_W'(BG_MAX - 1);
        end
        ST_BG: begin
          next_state    = ST_SPR;
          spr_start_nxt = 1'b1;
          timer_load    = 1'b1;
          timer_val     = CNT_W'(SPR_MAX - 1);
        end
        default: next_state = ST_DONE;
      endcase
    end else if (state == ST_DONE) begin
      next_state = ST_IDLE;
    end
  end

  assign busy = grant_valid;

  // Registered pulses, latched line and the granted VRAM address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eval_start <= 1'b0;
      bg_start   <= 1'b0;
      spr_start  <= 1'b0;
      overrun    <= 1'b0;
      line_done  <= 1'b0;
      line_out   <= '0;
      vaddr      <= '0;
    end else begin
      eval_start <= eval_start_nxt;
      bg_start   <= bg_start_nxt;
      spr_start  <= spr_start_nxt;
      overrun    <= overrun_nxt;
      line_done  <= (state == ST_DONE);
      if (latch_line) begin
        line_out <= line;
      end
      if (grant_valid) begin
        vaddr <= grant_addr;
      end
    end
  end

  // Two-stage owner tag: one stage for vaddr, one for the VRAM read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_valid <= 1'b0;
      p1_owner <= OWNER_EVAL;
      rd_valid <= 1'b0;
      rd_owner <= OWNER_EVAL;
    end else begin
      p1_valid <= grant_valid;
      p1_owner <= grant_valid ? grant_owner : OWNER_EVAL;
      rd_valid <= p1_valid;
      rd_owner <= p1_valid ? p1_owner : OWNER_EVAL;
    end
  end

endmodule

// File: tb/tb_render_sched.sv
// Self-checking bench for render_sched: directed line sequences plus random
// traffic, compared every cycle against a phase/cycle-count reference model.
module tb_render_sched;
  import video_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LINE_W-1:0] line;
  logic [ADDR_W-1:0] eval_addr, bg_addr, spr_addr;
  logic              eval_done, bg_done, spr_done;
  logic [ADDR_W-1:0] vaddr;
  logic              rd_valid;
  logic [1:0]        rd_owner;
  logic              eval_start, bg_start, spr_start;
  logic [LINE_W-1:0] line_out;
  logic              busy, line_done, overrun, timeout;

  render_sched dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .line       (line),
    .eval_addr  (eval_addr),
    .bg_addr    (bg_addr),
    .spr_addr   (spr_addr),
    .eval_done  (eval_done),
    .bg_done    (bg_done),
    .spr_done   (spr_done),
    .vaddr      (vaddr),
    .rd_valid   (rd_valid),
    .rd_owner   (rd_owner),
    .eval_start (eval_start),
    .bg_start   (bg_start),
    .spr_start  (spr_start),
    .line_out   (line_out),
    .busy       (busy),
    .line_done  (line_done),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int num_checks = 0;
  int num_fails  = 0;

  // Reference model: phase 0 idle, 1 eval, 2 bg, 3 spr, 4 done; m_cnt is the
  // 1-based cycle index inside the current phase.
  int          limit [5] = '{0, EVAL_MAX_DEF, BG_MAX_DEF, SPR_MAX_DEF, 0};
  int          m_phase, m_cnt;
  logic [7:0]  m_line;
  logic [12:0] m_vaddr;
  bit          e_eval_start, e_bg_start, e_spr_start, e_overrun, e_line_done;
  bit          d1_valid, d2_valid;
  logic [1:0]  d1_owner, d2_owner;

  bit          rand_addr = 1'b1;
  int          stray_spr_cycle = 0;
  int          cur_phase, cur_cnt;
  int          obs_busy, obs_line_done, obs_overrun, obs_tmo, obs_tmo_phase, obs_tmo_cycle;
  logic [13:0] spr_addr_wide;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_phase = 0; m_cnt = 0; m_line = '0; m_vaddr = '0;
    e_eval_start = 0; e_bg_start = 0; e_spr_start = 0; e_overrun = 0; e_line_done = 0;
    d1_valid = 0; d2_valid = 0; d1_owner = '0; d2_owner = '0;
  endtask

  task automatic clearObs();
    obs_busy = 0; obs_line_done = 0; obs_overrun = 0;
    obs_tmo = 0; obs_tmo_phase = -1; obs_tmo_cycle = -1;
  endtask

  task automatic applyStimulus(input bit st, input logic [7:0] ln, input bit ed, input bit bd, input bit sd);
    bit dn, busy_m, exp_tmo;
    @(negedge clk);
    start = st; line = ln; eval_done = ed; bg_done = bd; spr_done = sd;
    if (rand_addr) begin
      eval_addr = 13'($urandom);
      bg_addr   = 13'($urandom);
      spr_addr  = 13'($urandom);
    end
    #1;
    busy_m  = (m_phase >= 1 && m_phase <= 3);
    dn      = (m_phase == 1 && ed) || (m_phase == 2 && bd) || (m_phase == 3 && sd);
    exp_tmo = busy_m && (m_cnt == limit[m_phase]) && !dn && !st;
    cur_phase = m_phase; cur_cnt = m_cnt;

    checkOutput("busy",       32'(busy),       32'(busy_m));
    checkOutput("line_out",   32'(line_out),   32'(m_line));
    checkOutput("vaddr",      32'(vaddr),      32'(m_vaddr));
    checkOutput("rd_valid",   32'(rd_valid),   32'(d2_valid));
    checkOutput("rd_owner",   32'(rd_owner),   32'(d2_owner));
    checkOutput("eval_start", 32'(eval_start), 32'(e_eval_start));
    checkOutput("bg_start",   32'(bg_start),   32'(e_bg_start));
    checkOutput("spr_start",  32'(spr_start),  32'(e_spr_start));
    checkOutput("overrun",    32'(overrun),    32'(e_overrun));
    checkOutput("line_done",  32'(line_done),  32'(e_line_done));
    checkOutput("timeout",    32'(timeout),    32'(exp_tmo));

    obs_busy      += int'(busy);
    obs_line_done += int'(line_done);
    obs_overrun   += int'(overrun);
    if (timeout) begin
      obs_tmo++; obs_tmo_phase = cur_phase; obs_tmo_cycle = cur_cnt;
    end

    // Advance the model across the coming clock edge.
    d2_valid = d1_valid; d2_owner = d1_owner;
    d1_valid = busy_m;
    d1_owner = busy_m ? 2'(m_phase - 1) : 2'd0;
    if (busy_m) m_vaddr = (m_phase == 1) ? eval_addr : (m_phase == 2) ? bg_addr : spr_addr;
    e_line_done  = (m_phase == 4);
    e_eval_start = 0; e_bg_start = 0; e_spr_start = 0; e_overrun = 0;
    if (st) begin
      e_overrun = busy_m; e_eval_start = 1; m_line = ln; m_phase = 1; m_cnt = 1;
    end else if (busy_m) begin
      if (dn || m_cnt == limit[m_phase]) begin
        m_phase++; m_cnt = 1;
        e_bg_start  = (m_phase == 2);
        e_spr_start = (m_phase == 3);
      end else begin
        m_cnt++;
      end
    end else if (m_phase == 4) begin
      m_phase = 0;
    end
  endtask

  // Renders one line; a phase's done strobe fires on its n-th cycle (0 = never).
  // Optionally restarts with line rln at cycle rc of phase rp.
  task automatic runLine(input logic [7:0] ln, input int ne, input int nb, input int ns,
                         input int rp, input int rc, input logic [7:0] rln);
    bit restarted = 0;
    bit st;
    clearObs();
    applyStimulus(1'b1, ln, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 600 && m_phase != 0; i++) begin
      st = !restarted && rp != 0 && m_phase == rp && m_cnt == rc;
      if (st) restarted = 1;
      applyStimulus(st, st ? rln : 8'($urandom),
                    m_phase == 1 && m_cnt == ne,
                    m_phase == 2 && m_cnt == nb,
                    (m_phase == 3 && m_cnt == ns) || (m_phase == 1 && m_cnt == stray_spr_cycle));
    end
    checkOutput("seq_terminates", 32'(m_phase), 32'd0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic midReset();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_vaddr",      32'(vaddr),      32'd0);
    checkOutput("rst_line_out",   32'(line_out),   32'd0);
    checkOutput("rst_rd_valid",   32'(rd_valid),   32'd0);
    checkOutput("rst_rd_owner",   32'(rd_owner),   32'd0);
    checkOutput("rst_eval_start", 32'(eval_start), 32'd0);
    checkOutput("rst_bg_start",   32'(bg_start),   32'd0);
    checkOutput("rst_spr_start",  32'(spr_start),  32'd0);
    checkOutput("rst_line_done",  32'(line_done),  32'd0);
    checkOutput("rst_overrun",    32'(overrun),    32'd0);
    checkOutput("rst_timeout",    32'(timeout),    32'd0);
    modelReset();
    start = 0; eval_done = 0; bg_done = 0; spr_done = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 0; line = '0;
    eval_addr = '0; bg_addr = '0; spr_addr = '0;
    eval_done = 0; bg_done = 0; spr_done = 0;
    modelReset();
    clearObs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Nominal line with fixed addresses; 0x2000 does not fit 13 bits, so the
    // port carries its low 13 bits.
    $display("[TB] nominal line 0x20");
    rand_addr = 0;
    spr_addr_wide = 14'h2000;
    eval_addr = 13'h1F00; bg_addr = 13'h0800; spr_addr = spr_addr_wide[12:0];
    runLine(8'h20, 11, 11, 11, 0, 0, 8'h00);
    checkOutput("nominal_busy_cycles", 32'(obs_busy),      32'd33);
    checkOutput("nominal_line_done",   32'(obs_line_done), 32'd1);
    checkOutput("nominal_timeouts",    32'(obs_tmo),       32'd0);
    rand_addr = 1;

    $display("[TB] background timeout");
    runLine(8'h55, 5, 0, 4, 0, 0, 8'h00);
    checkOutput("bg_tmo_count", 32'(obs_tmo),       32'd1);
    checkOutput("bg_tmo_phase", 32'(obs_tmo_phase), 32'd2);
    checkOutput("bg_tmo_cycle", 32'(obs_tmo_cycle), 32'd140);

    $display("[TB] overrun during background");
    runLine(8'h2F, 3, 0, 6, 2, 5, 8'h30);
    checkOutput("ovr_count",     32'(obs_overrun),   32'd1);
    checkOutput("ovr_line_done", 32'(obs_line_done), 32'd1);
    checkOutput("ovr_line_out",  32'(line_out),      32'h30);

    $display("[TB] done coincident with eval timeout");
    stray_spr_cycle = 10;
    runLine(8'h41, 80, 3, 3, 0, 0, 8'h00);
    stray_spr_cycle = 0;
    checkOutput("coinc_timeouts",    32'(obs_tmo),  32'd0);
    checkOutput("coinc_busy_cycles", 32'(obs_busy), 32'd86);

    $display("[TB] reset during sprite phase");
    clearObs();
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !(m_phase == 3 && m_cnt == 4); i++)
      applyStimulus(1'b0, 8'h00, m_phase == 1 && m_cnt == 2, m_phase == 2 && m_cnt == 2, 1'b0);
    midReset();
    runLine(8'h67, 4, 4, 4, 0, 0, 8'h00);
    checkOutput("post_rst_busy_cycles", 32'(obs_busy),      32'd12);
    checkOutput("post_rst_line_done",   32'(obs_line_done), 32'd1);

    // Random traffic: alternate blocks of frequent and rare done strobes so
    // both early completion and budget timeouts get exercised.
    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      int p;
      p = ((i / 500) % 2 == 1) ? 150 : 8;
      applyStimulus($urandom_range(0, 59) == 0, 8'($urandom),
                    $urandom_range(0, p) == 0,
                    $urandom_range(0, p) == 0,
                    $urandom_range(0, p) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/render_sched.md
RENDER_SCHED -- requirements
Module: render_sched

Interface
REQ-001 SHALL have parameter EVAL_MAX, 80: maximum vclk cycles allowed for the sprite-evaluation phase.
REQ-002 SHALL have parameter BG_MAX, 140: maximum vclk cycles allowed for the background-fetch phase.
REQ-003 SHALL have parameter SPR_MAX, 40: maximum vclk cycles allowed for the sprite-pattern phase.
REQ-004 SHALL have port clk, input, 1: video clock (vclk domain); one clock only.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to render one line.
REQ-007 SHALL have port line, input, 8: line number to render, sampled with start.
REQ-008 SHALL have ports eval_addr, bg_addr and spr_addr, input, 13 each: VRAM word addresses from the evaluator, the background fetcher and the sprite fetcher.
REQ-009 SHALL have ports eval_done, bg_done and spr_done, input, 1 each: requester phase-complete strobes.
REQ-010 SHALL have port vaddr, output, 13: registered address to the video-side VRAM port.
REQ-011 SHALL have port rd_valid, output, 1: the VRAM read data on this cycle belongs to rd_owner.
REQ-012 SHALL have port rd_owner, output, 2: owner of the read data (0 eval, 1 bg, 2 spr).
REQ-013 SHALL have ports eval_start, bg_start and spr_start, output, 1 each: one-cycle phase-start pulses.
REQ-014 SHALL have port line_out, output, 8: latched line number for the requesters.
REQ-015 SHALL have port busy, output, 1: a sequence is in progress.
REQ-016 SHALL have ports line_done, overrun and timeout, output, 1 each: one-cycle status pulses.

Function
REQ-017 SHALL implement the states IDLE, EVAL, BG, SPR and DONE.
REQ-018 SHALL, in IDLE on start, latch line into line_out, pulse eval_start the next cycle and enter EVAL.
REQ-019 SHALL transition EVAL->BG on eval_done, BG->SPR on bg_done and SPR->DONE on spr_done.
  - Each transition SHALL pulse the next phase's *_start exactly one cycle after the done strobe.
REQ-020 SHALL, in DONE, pulse line_done for one cycle, deassert busy and return to IDLE.
REQ-021 SHALL drive busy=1 in EVAL, BG and SPR, and busy=0 in IDLE and DONE.
REQ-022 SHALL register the granted requester's address into vaddr each cycle.
  - The grant is fixed by state: EVAL->eval_addr, BG->bg_addr, SPR->spr_addr.
  - In IDLE and DONE, vaddr SHALL hold its last value.
REQ-023 SHALL assert rd_valid and rd_owner exactly two cycles after a granted cycle: one cycle for the vaddr register plus one cycle of VRAM read latency.
REQ-024 SHALL ignore a done strobe that does not belong to the current state.
REQ-025 SHALL count cycles per phase with a counter that clears on entry to each phase.
  - When the count reaches the phase's *_MAX, the block SHALL pulse timeout and advance as if done had arrived.
REQ-026 SHALL, on start while busy: pulse overrun, abandon the current phase, latch the new line and restart at EVAL with eval_start.
  - The rd_valid pipeline already in flight SHALL still complete.
REQ-027 SHALL, when a done strobe and a timeout occur in the same cycle, advance once and NOT pulse timeout.
REQ-028 SHALL give start priority over a done strobe in the same cycle (overrun path).
REQ-029 SHALL size the cycle counter for max(EVAL_MAX, BG_MAX, SPR_MAX) and SHALL NOT let it wrap.

Reset
REQ-030 SHALL, on reset, asynchronously force: state=IDLE, vaddr=0, line_out=0, and busy, rd_valid, rd_owner, every *_start, line_done, overrun, timeout and the cycle counter all to 0.
REQ-031 SHALL, on reset asserted mid-sequence, abort the sequence without emitting line_done or any pulse.

Structure
REQ-032 SHALL take the state encoding, the owner IDs (0/1/2) and the default *_MAX values from the shared video package (video_pkg).
REQ-033 SHALL instantiate one sub-module, phase_timer: a loadable down-counter with a terminal-count strobe.

Verification
REQ-034 Start with line=0x20, each done strobe issued 10 cycles after its *_start -> eval_start, bg_start and spr_start are each 1 cycle; line_out=0x20; line_done arrives 1 cycle after DONE is reached; busy is high for 33 cycles.
REQ-035 Addresses 0x1F00, 0x0800 and 0x2000 on the three ports -> vaddr follows the owner of each phase; rd_owner lags the grant by 2 cycles with rd_valid=1.
REQ-036 bg_done withheld -> timeout pulses at cycle 140 of BG; spr_start follows on the next cycle.
REQ-037 Start line 0x30 during BG of line 0x2F -> overrun pulses; line_out=0x30; eval_start re-pulses; no line_done for 0x2F.
REQ-038 eval_done coincident with the EVAL timeout -> one BG entry, no timeout pulse; a stray spr_done during EVAL is ignored.
REQ-039 Reset asserted during SPR -> all outputs 0 immediately; the next start runs a clean sequence.
